// File: rtl/reducer.sv
// Projective-to-affine converter over GF(2^255-19): x = X/Z, y = Y/Z, streamed as two beats.
// Optional REDUCER_CANON_IN_EN: reduce captured inputs in [Q, 2^255) by one subtraction of Q.
module reducer (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_ptadd_valid,
    input  logic [254:0] i_ptadd_xmp,
    input  logic [254:0] i_ptadd_ymp,
    input  logic [254:0] i_ptadd_zmp,
    output logic         o_ptadd_ready,
    input  logic         i_dataout_ready,
    output logic [254:0] o_dataout_xg,
    output logic [254:0] o_dataout_yg,
    output logic         o_dataout_valid
);

    localparam logic [254:0] Q  = 255'd0 - 255'd19;
    localparam logic [254:0] HQ = (Q >> 1) + 255'd1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_INV  = 3'd1;
    localparam logic [2:0] S_MULX = 3'd2;
    localparam logic [2:0] S_MULY = 3'd3;
    localparam logic [2:0] S_OUT0 = 3'd4;
    localparam logic [2:0] S_OUT1 = 3'd5;

    logic [2:0]   state;
    logic [254:0] xr, yr, u, v, x1, x2, acc;
    logic [7:0]   cnt;
    logic [254:0] x_in, y_in, z_in;

`ifdef REDUCER_CANON_IN_EN
    always_comb begin
        x_in = (i_ptadd_xmp >= Q) ? i_ptadd_xmp - Q : i_ptadd_xmp;
        y_in = (i_ptadd_ymp >= Q) ? i_ptadd_ymp - Q : i_ptadd_ymp;
        z_in = (i_ptadd_zmp >= Q) ? i_ptadd_zmp - Q : i_ptadd_zmp;
    end
`else
    always_comb begin
        x_in = i_ptadd_xmp;
        y_in = i_ptadd_ymp;
        z_in = i_ptadd_zmp;
    end
`endif

    logic [254:0] x1_half, x2_half, x1_sub, x2_sub, mul_b, addend, acc_next;
    logic [256:0] m_t, m_t1;

    always_comb begin
        // (x+Q)>>1 for odd x is (x>>1) + (Q+1)/2, which keeps the sum within 255 bits
        x1_half  = {1'b0, x1[254:1]} + (x1[0] ? HQ : '0);
        x2_half  = {1'b0, x2[254:1]} + (x2[0] ? HQ : '0);
        x1_sub   = x1 - x2 + ((x1 >= x2) ? '0 : Q);
        x2_sub   = x2 - x1 + ((x2 >= x1) ? '0 : Q);
        mul_b    = (state == S_MULY) ? yr : xr;
        addend   = mul_b[cnt] ? x1 : '0;
        m_t      = {1'b0, acc, 1'b0} + {2'b00, addend};
        m_t1     = (m_t >= {2'b00, Q}) ? m_t - {2'b00, Q} : m_t;
        acc_next = (m_t1 >= {2'b00, Q}) ? m_t1[254:0] - Q : m_t1[254:0];
    end

    always_comb o_ptadd_ready = (state == S_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= S_IDLE;
            o_dataout_valid <= 1'b0;
            o_dataout_xg    <= '0;
            o_dataout_yg    <= '0;
        end else begin
            case (state)
                S_IDLE: if (i_ptadd_valid) begin
                    xr <= x_in;
                    yr <= y_in;
                    if (z_in == '0) begin
                        o_dataout_xg    <= '0;
                        o_dataout_yg    <= '0;
                        o_dataout_valid <= 1'b1;
                        state           <= S_OUT0;
                    end else begin
                        u     <= z_in;
                        v     <= Q;
                        x1    <= 255'd1;
                        x2    <= '0;
                        state <= S_INV;
                    end
                end
                S_INV: begin
                    // u or v reaching 0 only happens for Z a multiple of Q; it ends the loop with inv=0
                    if (u == 255'd1 || v == 255'd1 || u == '0 || v == '0) begin
                        if (u != 255'd1) x1 <= (v == 255'd1) ? x2 : '0;
                        acc   <= '0;
                        cnt   <= 8'd254;
                        state <= S_MULX;
                    end else if (!u[0]) begin
                        u  <= u >> 1;
                        x1 <= x1_half;
                    end else if (!v[0]) begin
                        v  <= v >> 1;
                        x2 <= x2_half;
                    end else if (u >= v) begin
                        u  <= u - v;
                        x1 <= x1_sub;
                    end else begin
                        v  <= v - u;
                        x2 <= x2_sub;
                    end
                end
                S_MULX: begin
                    cnt <= cnt - 8'd1;
                    acc <= acc_next;
                    if (cnt == 8'd0) begin
                        xr    <= acc_next;
                        acc   <= '0;
                        cnt   <= 8'd254;
                        state <= S_MULY;
                    end
                end
                S_MULY: begin
                    cnt <= cnt - 8'd1;
                    acc <= acc_next;
                    if (cnt == 8'd0) begin
                        o_dataout_xg    <= xr;
                        o_dataout_yg    <= acc_next;
                        o_dataout_valid <= 1'b1;
                        state           <= S_OUT0;
                    end
                end
                S_OUT0: if (i_dataout_ready) begin
                    o_dataout_xg <= o_dataout_yg;
                    state        <= S_OUT1;
                end
                S_OUT1: if (i_dataout_ready) begin
                    o_dataout_valid <= 1'b0;
                    state           <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reducer.sv
// Self-checking bench for reducer: constant vector table, random vectors against a
// Fermat-inverse reference model, backpressure and mid-operation reset sequences.
module tb_reducer;

    localparam logic [254:0] Q = 255'd0 - 255'd19;

    logic         clk = 1'b0;
    logic         rst, pv, pr, dr, dv;
    logic [254:0] px, py, pz, xg, yg;

    always #5 clk = ~clk;

    reducer dut (
        .i_clk(clk), .i_rst(rst), .i_ptadd_valid(pv),
        .i_ptadd_xmp(px), .i_ptadd_ymp(py), .i_ptadd_zmp(pz),
        .o_ptadd_ready(pr), .i_dataout_ready(dr),
        .o_dataout_xg(xg), .o_dataout_yg(yg), .o_dataout_valid(dv)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [254:0] x, y, z, ex, ey;
    } vec_t;

    task automatic chk(input string name, input logic [254:0] got, input logic [254:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [254:0] mulmod(input logic [254:0] a, input logic [254:0] b);
        logic [509:0] p;
        p = {255'd0, a} * {255'd0, b};
        p = p % {255'd0, Q};
        return p[254:0];
    endfunction

    function automatic logic [254:0] powmod(input logic [254:0] a, input logic [254:0] e);
        logic [254:0] r;
        r = 255'd1;
        for (int i = 254; i >= 0; i--) begin
            r = mulmod(r, r);
            if (e[i]) r = mulmod(r, a);
        end
        return r;
    endfunction

    function automatic logic [254:0] rnd255();
        logic [255:0] t;
        logic [254:0] r;
        for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
        r = t[254:0];
        if (r >= Q) r = r - Q;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [254:0] X, input logic [254:0] Y, input logic [254:0] Z,
                          output logic [254:0] b0x, output logic [254:0] b0y, output logic [254:0] b1x,
                          output int lat, output logic b1v, output logic endv, output logic tmo);
        b0x = '0; b0y = '0; b1x = '0; b1v = 1'b0; endv = 1'b1; tmo = 1'b0; lat = 0;
        pv = 1'b1; px = X; py = Y; pz = Z;
        tick();
        pv = 1'b0;
        while (!dv && lat < 2000) begin
            tick();
            lat++;
        end
        if (!dv) begin
            tmo = 1'b1;
            return;
        end
        b0x = xg;
        b0y = yg;
        tick();
        b1v = dv;
        b1x = xg;
        tick();
        endv = dv;
    endtask

    task automatic check_vec(input string name, input logic [254:0] X, input logic [254:0] Y,
                             input logic [254:0] Z, input logic [254:0] ex, input logic [254:0] ey,
                             input int maxlat);
        logic [254:0] b0x, b0y, b1x;
        logic         b1v, endv, tmo;
        int           lat;
        chk({name, " idle_ready"}, pr, 1);
        run_op(X, Y, Z, b0x, b0y, b1x, lat, b1v, endv, tmo);
        chk({name, " timeout"}, tmo, 0);
        chk({name, " beat0_x"}, b0x, ex);
        chk({name, " beat0_y"}, b0y, ey);
        chk({name, " beat1_valid"}, b1v, 1);
        chk({name, " beat1_y"}, b1x, ey);
        chk({name, " valid_drop"}, endv, 0);
        chk({name, " latency_ok"}, lat <= maxlat, 1);
    endtask

    vec_t tbl[6];

    initial begin
        logic [254:0] X, Y, Z, iz, ex, ey;
        int           lat;
        logic         busy_ready, stable;

        tbl[0] = '{x: 255'd5, y: Q - 255'd1, z: 255'd1, ex: 255'd5, ey: Q - 255'd1};
        tbl[1] = '{x: 255'd2, y: 255'd4, z: 255'd2, ex: 255'd1, ey: 255'd2};
        tbl[2] = '{x: 255'd6, y: 255'd9, z: 255'd3, ex: 255'd2, ey: 255'd3};
        tbl[3] = '{x: Q - 255'd1, y: 255'd1, z: Q - 255'd1, ex: 255'd1, ey: Q - 255'd1};
        tbl[4] = '{x: 255'd0, y: 255'd7, z: 255'd7, ex: 255'd0, ey: 255'd1};
        tbl[5] = '{x: Q - 255'd3, y: 255'd12345, z: 255'd1, ex: Q - 255'd3, ey: 255'd12345};

        rst = 1'b1; pv = 1'b0; dr = 1'b1; px = '0; py = '0; pz = '0;
        repeat (3) tick();
        chk("reset ready", pr, 1);
        chk("reset valid", dv, 0);
        chk("reset xg", xg, 0);
        chk("reset yg", yg, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++)
            check_vec($sformatf("tbl%0d", i), tbl[i].x, tbl[i].y, tbl[i].z, tbl[i].ex, tbl[i].ey, 1600);

        check_vec("zero_z", rnd255(), rnd255(), 255'd0, 255'd0, 255'd0, 3);

        for (int i = 0; i < 12; i++) begin
            X = rnd255(); Y = rnd255();
            Z = rnd255();
            if (Z == '0) Z = 255'd9;
            iz = powmod(Z, Q - 255'd2);
            check_vec($sformatf("rnd%0d", i), X, Y, Z, mulmod(X, iz), mulmod(Y, iz), 1600);
        end

        // Backpressure with a competing valid request held high throughout the operation
        X = rnd255(); Y = rnd255(); Z = rnd255() | 255'd1;
        iz = powmod(Z, Q - 255'd2);
        ex = mulmod(X, iz); ey = mulmod(Y, iz);
        dr = 1'b0;
        pv = 1'b1; px = X; py = Y; pz = Z;
        tick();
        px = rnd255(); py = rnd255(); pz = 255'd1;
        busy_ready = 1'b0; lat = 0;
        while (!dv && lat < 2000) begin
            busy_ready = busy_ready | pr;
            tick();
            lat++;
        end
        chk("bp reached_out0", dv, 1);
        chk("bp no_ready_busy", busy_ready, 0);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            stable = stable & dv & (xg == ex) & (yg == ey) & ~pr;
            tick();
        end
        chk("bp out0_hold", stable, 1);
        chk("bp out0_x", xg, ex);
        chk("bp out0_y", yg, ey);
        dr = 1'b1;
        tick();
        dr = 1'b0;
        chk("bp out1_valid", dv, 1);
        chk("bp out1_x", xg, ey);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            stable = stable & dv & (xg == ey) & ~pr;
            tick();
        end
        chk("bp out1_hold", stable, 1);
        pv = 1'b0;
        dr = 1'b1;
        tick();
        chk("bp done_valid", dv, 0);
        chk("bp done_ready", pr, 1);

        // Reset in the middle of the inversion
        pv = 1'b1; px = rnd255(); py = rnd255(); pz = rnd255() | 255'd1;
        tick();
        pv = 1'b0;
        repeat (20) tick();
        chk("midrst busy", pr, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst ready", pr, 1);
        chk("midrst valid", dv, 0);
        X = rnd255(); Y = rnd255(); Z = rnd255() | 255'd2;
        iz = powmod(Z, Q - 255'd2);
        check_vec("post_rst", X, Y, Z, mulmod(X, iz), mulmod(Y, iz), 1600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
